rx_fifo_pckt_wr_ctrl: RTL and testbench
=======================================

// Module: rx_fifo_pckt_wr_ctrl
// PURPOSE
//  Packet-level write controller between the MAC RX stream and the async RX FIFO write side.
//  Writes each beat into the FIFO and commits good frames (commit = pulse fifo_latch_addr on the last beat).
//  Rewinds the FIFO write pointer to the last commit point (fifo_drop) for bad-CRC, overflow or oversize frames.
//  Rejects a whole frame when the FIFO is almost full at start of packet. Keeps saturating per-reason frame counters.
// PARAMETERS
//  DATA_WIDTH    8     width of stream/FIFO data
//  MAX_PCKT_LEN  1518  max beats per frame; more beats = oversize
//  CNT_WIDTH     32    width of statistics counters (saturating)
// PORTS
//  clk               in   1           clock
//  reset_n           in   1           synchronous, active-low reset
//  s_rx_tdata        in   DATA_WIDTH  RX beat data
//  s_rx_tvalid       in   1           beat valid; no backpressure, every valid beat is consumed
//  s_rx_tlast        in   1           last beat of frame
//  s_rx_tuser        in   1           bad-frame flag (CRC/PHY error), meaningful with tlast
//  fifo_wr_data      out  DATA_WIDTH  FIFO write data
//  fifo_wr           out  1           FIFO write strobe
//  fifo_full         in   1           FIFO full (already reflects the previous cycle's write)
//  fifo_almost_full  in   1           FIFO almost full
//  fifo_latch_addr   out  1           commit: FIFO saves write pointer + 1
//  fifo_drop         out  1           rewind: FIFO restores last committed pointer
//  good_cnt          out  CNT_WIDTH   frames committed
//  bad_cnt           out  CNT_WIDTH   frames dropped: tuser on last beat
//  ovf_cnt           out  CNT_WIDTH   frames dropped: almost_full at SOP or full mid-frame
//  oversize_cnt      out  CNT_WIDTH   frames dropped: length > MAX_PCKT_LEN
// BEHAVIOUR
//  - Reset: state=IDLE, stage valid=0, beat count=0. All outputs 0, including all counters. Upstream MAC shares the reset, so the first post-reset beat is an SOP.
//  - One-deep stage register captures {tdata,tlast,tuser} on each valid beat, so the write follows the input by 1 cycle.
//  - Write strobes are decoded combinationally from the stage register and fifo_full; no other logic in that path.
//  - fifo_wr_data = stage data at all times.
//  - States:
//    IDLE: a staged beat is an SOP.
//      If fifo_almost_full=1: no write, no drop, ovf_cnt++; go to DISCARD (or stay in IDLE if the beat is last).
//      Otherwise handle the beat as in WRITE.
//    WRITE, staged beat, in priority order:
//      a) fifo_full=1: fifo_wr=0, fifo_drop=1, ovf_cnt++; go to DISCARD, or IDLE if the beat is last.
//      b) beat count == MAX_PCKT_LEN (this beat would exceed it): fifo_wr=0, fifo_drop=1, oversize_cnt++; go to DISCARD, or IDLE if last.
//      c) last & tuser: fifo_wr=0, fifo_drop=1, bad_cnt++; go to IDLE.
//      d) last & !tuser: fifo_wr=1, fifo_latch_addr=1, good_cnt++; go to IDLE.
//      e) otherwise: fifo_wr=1, beat count++.
//    DISCARD: staged beats are never written; no drop pulse. Go to IDLE on the staged last beat.
//  - Beat count clears on every entry to IDLE. It counts written beats of the current frame and is at least clog2(MAX_PCKT_LEN+1) bits.
//  - fifo_wr and fifo_drop are never high in the same cycle, because the FIFO ignores writes during a rewind.
//  - fifo_drop and fifo_latch_addr are never high in the same cycle. Each is a 1-cycle pulse per frame at most.
//  - A frame that reaches fifo_drop has written at least 0 beats. A drop with 0 written beats (bad single-beat frame) is legal and is a no-op rewind.
//  - Back-to-back frames with no idle cycles: the SOP directly after a last beat goes through IDLE handling in the next cycle. No beat is lost.
//  - Counters saturate at all-ones and never wrap. Exactly one counter increments per frame.
//  - Reset asserted mid-frame: all state clears. No drop pulse is issued, because the FIFO pointers reset together with this block.
// STRUCTURE
//  - Package rx_fifo_ctrl_pkg holds:
//    - typedef enum {IDLE, WRITE, DISCARD} wr_state_t
//    - typedef enum drop_reason_t {NONE, BAD, OVF, OVERSIZE}
//  - Sub-module sat_counter #(CNT_WIDTH): clk, reset_n, inc, count. Instanced 4 times.
// TESTING
//  1. Good 4-beat frame, empty FIFO -> fifo_wr on 4 cycles, 1 cycle after each beat; fifo_latch_addr with the 4th write; good_cnt=1.
//  2. 4-beat frame, tuser=1 on last -> 3 writes; cycle 4: fifo_wr=0, fifo_drop=1; bad_cnt=1; no latch.
//  3. 6-beat frame, fifo_full forced high from beat 3 -> writes 1-2; drop on beat 3; beats 4-6 not written; ovf_cnt=1; next frame fully written and committed.
//  4. fifo_almost_full=1 at SOP of 5-beat frame -> zero writes, zero drop pulses, ovf_cnt=1. Deassert it -> next frame committed, good_cnt=1.
//  5. MAX_PCKT_LEN=8, 10-beat frame -> 8 writes; drop on beat 9; beat 10 discarded; oversize_cnt=1.
//  6. Three back-to-back single-beat frames (good, bad, good) -> write+latch, drop, write+latch; good_cnt=2, bad_cnt=1.
//     Then reset mid-frame -> all outputs 0 and the next frame commits normally.

Source files
------------

// File: rtl/rx_fifo_pckt_wr_ctrl_pkg.sv
// Shared types for the RX FIFO packet write controller: FSM states and the
// reason a frame was thrown away.
package rx_fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DISCARD
    } wr_state_t;

    typedef enum logic [1:0] {
        NONE,
        BAD,
        OVF,
        OVERSIZE
    } drop_reason_t;

endpackage

// File: rtl/rx_fifo_pckt_wr_ctrl_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    // Count up on each increment request until the counter is saturated
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/rx_fifo_pckt_wr_ctrl.sv
// Packet-level write controller between the MAC RX stream and the RX FIFO.
// Good frames are committed on their last beat; bad, overflowing or oversize
// frames are rewound to the last commit point; frames arriving while the FIFO
// is almost full are rejected whole.
module rx_fifo_pckt_wr_ctrl
    import rx_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_PCKT_LEN = 1518,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] s_rx_tdata,
    input  logic                  s_rx_tvalid,
    input  logic                  s_rx_tlast,
    input  logic                  s_rx_tuser,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  fifo_wr,
    input  logic                  fifo_full,
    input  logic                  fifo_almost_full,
    output logic                  fifo_latch_addr,
    output logic                  fifo_drop,
    output logic [CNT_WIDTH-1:0]  good_cnt,
    output logic [CNT_WIDTH-1:0]  bad_cnt,
    output logic [CNT_WIDTH-1:0]  ovf_cnt,
    output logic [CNT_WIDTH-1:0]  oversize_cnt
);

    localparam int BCW = $clog2(MAX_PCKT_LEN + 1);

    wr_state_t       state, state_nxt;
    logic [BCW-1:0]  beat_cnt, beat_cnt_nxt;
    logic                  stg_valid;
    logic [DATA_WIDTH-1:0] stg_data;
    logic                  stg_last;
    logic                  stg_user;
    logic            do_write;
    logic            good_inc;
    drop_reason_t    reason;

    assign fifo_wr_data = stg_data;

    // Stage each valid input beat so its FIFO handling happens one cycle later
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stg_valid <= 1'b0;
            stg_data  <= '0;
            stg_last  <= 1'b0;
            stg_user  <= 1'b0;
        end else begin
            stg_valid <= s_rx_tvalid;
            if (s_rx_tvalid) begin
                stg_data <= s_rx_tdata;
                stg_last <= s_rx_tlast;
                stg_user <= s_rx_tuser;
            end
        end
    end

    // Frame state and the count of beats written for the current frame
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // Decide what happens to the staged beat: write, commit, rewind or discard
    always_comb begin
        state_nxt       = state;
        beat_cnt_nxt    = beat_cnt;
        do_write        = 1'b0;
        fifo_wr         = 1'b0;
        fifo_drop       = 1'b0;
        fifo_latch_addr = 1'b0;
        good_inc        = 1'b0;
        reason          = NONE;
        if (stg_valid) begin
            case (state)
                IDLE: begin
                    if (fifo_almost_full) begin
                        reason    = OVF;
                        state_nxt = stg_last ? IDLE : DISCARD;
                    end else begin
                        do_write = 1'b1;
                    end
                end
                WRITE: begin
                    do_write = 1'b1;
                end
                DISCARD: begin
                    if (stg_last) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
            if (do_write) begin
                if (fifo_full) begin
                    fifo_drop = 1'b1;
                    reason    = OVF;
                    state_nxt = stg_last ? IDLE : DISCARD;
                end else if (beat_cnt == BCW'(MAX_PCKT_LEN)) begin
                    fifo_drop = 1'b1;
                    reason    = OVERSIZE;
                    state_nxt = stg_last ? IDLE : DISCARD;
                end else if (stg_last && stg_user) begin
                    fifo_drop = 1'b1;
                    reason    = BAD;
                    state_nxt = IDLE;
                end else if (stg_last) begin
                    fifo_wr         = 1'b1;
                    fifo_latch_addr = 1'b1;
                    good_inc        = 1'b1;
                    state_nxt       = IDLE;
                end else begin
                    fifo_wr      = 1'b1;
                    beat_cnt_nxt = beat_cnt + BCW'(1);
                    state_nxt    = WRITE;
                end
            end
        end
        if (state_nxt == IDLE) begin
            beat_cnt_nxt = '0;
        end
    end

    // One saturating statistics counter per frame outcome
    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_good_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (good_inc),
        .count   (good_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bad_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (reason == BAD),
        .count   (bad_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_ovf_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (reason == OVF),
        .count   (ovf_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_oversize_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (reason == OVERSIZE),
        .count   (oversize_cnt)
    );

endmodule

// File: tb/tb_rx_fifo_pckt_wr_ctrl.sv
// Bench for rx_fifo_pckt_wr_ctrl: frames are described by length, bad flag,
// almost-full at SOP and the beat where the FIFO fills; the expected per-beat
// FIFO activity and counter increments are derived per frame with arithmetic.
module tb_rx_fifo_pckt_wr_ctrl;

    localparam int DW   = 8;
    localparam int MAXL = 8;
    localparam int CW   = 4;
    localparam int SAT  = (1 << CW) - 1;

    localparam int K_NONE = 0;
    localparam int K_GOOD = 1;
    localparam int K_BAD  = 2;
    localparam int K_OVF  = 3;
    localparam int K_OVS  = 4;

    logic          clk;
    logic          reset_n;
    logic [DW-1:0] s_rx_tdata;
    logic          s_rx_tvalid;
    logic          s_rx_tlast;
    logic          s_rx_tuser;
    logic [DW-1:0] fifo_wr_data;
    logic          fifo_wr;
    logic          fifo_full;
    logic          fifo_almost_full;
    logic          fifo_latch_addr;
    logic          fifo_drop;
    logic [CW-1:0] good_cnt;
    logic [CW-1:0] bad_cnt;
    logic [CW-1:0] ovf_cnt;
    logic [CW-1:0] oversize_cnt;

    int checks = 0;
    int errors = 0;

    int mGood = 0;
    int mBad  = 0;
    int mOvf  = 0;
    int mOvs  = 0;

    logic          pWr    = 1'b0;
    logic          pDrop  = 1'b0;
    logic          pLatch = 1'b0;
    logic          pFull  = 1'b0;
    logic          pAf    = 1'b0;
    logic [DW-1:0] pData  = '0;
    int            pKind  = 0;

    rx_fifo_pckt_wr_ctrl #(
        .DATA_WIDTH   (DW),
        .MAX_PCKT_LEN (MAXL),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .s_rx_tdata       (s_rx_tdata),
        .s_rx_tvalid      (s_rx_tvalid),
        .s_rx_tlast       (s_rx_tlast),
        .s_rx_tuser       (s_rx_tuser),
        .fifo_wr_data     (fifo_wr_data),
        .fifo_wr          (fifo_wr),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_latch_addr  (fifo_latch_addr),
        .fifo_drop        (fifo_drop),
        .good_cnt         (good_cnt),
        .bad_cnt          (bad_cnt),
        .ovf_cnt          (ovf_cnt),
        .oversize_cnt     (oversize_cnt)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int satInc(input int c);
        return (c < SAT) ? c + 1 : c;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkCounters();
        checkOutput("good_cnt", 32'(good_cnt), 32'(mGood));
        checkOutput("bad_cnt", 32'(bad_cnt), 32'(mBad));
        checkOutput("ovf_cnt", 32'(ovf_cnt), 32'(mOvf));
        checkOutput("oversize_cnt", 32'(oversize_cnt), 32'(mOvs));
    endtask

    // One clock cycle: present a new beat, set the FIFO flags seen by the
    // staged beat, check the staged beat's expected effect, then remember the
    // new beat's expectations for the next cycle.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic l, input logic u,
                                 input logic f, input logic a,
                                 input logic ew, input logic ed, input logic el, input int kind);
        fifo_full        = pFull;
        fifo_almost_full = pAf;
        s_rx_tvalid      = v;
        s_rx_tdata       = d;
        s_rx_tlast       = l;
        s_rx_tuser       = u;
        #1;
        checkOutput("fifo_wr", 32'(fifo_wr), 32'(pWr));
        checkOutput("fifo_drop", 32'(fifo_drop), 32'(pDrop));
        checkOutput("fifo_latch_addr", 32'(fifo_latch_addr), 32'(pLatch));
        if (pWr) checkOutput("fifo_wr_data", 32'(fifo_wr_data), 32'(pData));
        checkCounters();
        case (pKind)
            K_GOOD:  mGood = satInc(mGood);
            K_BAD:   mBad  = satInc(mBad);
            K_OVF:   mOvf  = satInc(mOvf);
            K_OVS:   mOvs  = satInc(mOvs);
            default: ;
        endcase
        pWr = ew; pDrop = ed; pLatch = el;
        pFull = f; pAf = a; pData = d; pKind = kind;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, DW'($urandom()), 1'($urandom()), 1'($urandom()),
                      1'($urandom()), 1'($urandom()), 1'b0, 1'b0, 1'b0, K_NONE);
    endtask

    // Send one frame; fullFrom = 0 means the FIFO never fills during it
    task automatic sendFrame(input int len, input bit bad, input bit af, input int fullFrom, input int gap);
        int writes, eventBeat, kind, f, stop;
        bit dropF, latchF;
        for (int g = 0; g < gap; g++) idleCycle();
        dropF = 0; latchF = 0;
        if (af) begin
            writes = 0; eventBeat = 1; kind = K_OVF;
        end else begin
            f    = (fullFrom == 0) ? 1000000 : fullFrom;
            stop = (f < MAXL + 1) ? f : MAXL + 1;
            if (stop <= len) begin
                writes = stop - 1; eventBeat = stop; dropF = 1;
                kind = (f == stop) ? K_OVF : K_OVS;
            end else if (bad) begin
                writes = len - 1; eventBeat = len; dropF = 1; kind = K_BAD;
            end else begin
                writes = len; eventBeat = len; latchF = 1; kind = K_GOOD;
            end
        end
        for (int i = 1; i <= len; i++) begin
            logic lst, usr, fl, al;
            lst = (i == len);
            usr = lst ? bad : 1'($urandom());
            fl  = af ? 1'($urandom()) : (fullFrom != 0 && i >= fullFrom);
            al  = (i == 1) ? af : 1'($urandom());
            applyStimulus(1'b1, DW'($urandom()), lst, usr, fl, al,
                          (i <= writes), (dropF && i == eventBeat), (latchF && i == eventBeat),
                          (i == eventBeat) ? kind : K_NONE);
        end
    endtask

    // Synchronous reset; afterwards every output must read zero
    task automatic doReset();
        reset_n          = 1'b0;
        s_rx_tvalid      = 1'b0;
        s_rx_tdata       = '0;
        s_rx_tlast       = 1'b0;
        s_rx_tuser       = 1'b0;
        fifo_full        = 1'b0;
        fifo_almost_full = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_fifo_wr", 32'(fifo_wr), 32'd0);
        checkOutput("rst_fifo_drop", 32'(fifo_drop), 32'd0);
        checkOutput("rst_latch", 32'(fifo_latch_addr), 32'd0);
        checkOutput("rst_wr_data", 32'(fifo_wr_data), 32'd0);
        mGood = 0; mBad = 0; mOvf = 0; mOvs = 0;
        checkCounters();
        pWr = 0; pDrop = 0; pLatch = 0; pFull = 0; pAf = 0; pData = '0; pKind = K_NONE;
        reset_n = 1'b1;
    endtask

    // Directed scenarios first, then randomized frames
    initial begin
        doReset();

        sendFrame(4, 0, 0, 0, 1);
        sendFrame(4, 1, 0, 0, 1);
        sendFrame(6, 0, 0, 3, 1);
        sendFrame(4, 0, 0, 0, 1);
        sendFrame(5, 0, 1, 0, 1);
        sendFrame(3, 0, 0, 0, 0);
        sendFrame(10, 0, 0, 0, 1);
        sendFrame(1, 0, 0, 0, 0);
        sendFrame(1, 1, 0, 0, 0);
        sendFrame(1, 0, 0, 0, 0);
        sendFrame(MAXL, 0, 0, 0, 0);
        sendFrame(MAXL + 1, 0, 0, 0, 0);
        sendFrame(MAXL + 2, 0, 0, MAXL + 1, 0);
        sendFrame(1, 0, 1, 0, 0);
        sendFrame(3, 0, 0, 1, 0);
        idleCycle();

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, DW'($urandom()), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, K_NONE);
        end
        doReset();
        sendFrame(4, 0, 0, 0, 0);
        idleCycle();

        for (int i = 0; i < 18; i++) sendFrame(1, 0, 0, 0, 0);
        idleCycle();

        for (int n = 0; n < 120; n++) begin
            int len, ff;
            bit bad, af;
            len = $urandom_range(1, MAXL + 4);
            bad = ($urandom_range(0, 3) == 0);
            af  = ($urandom_range(0, 5) == 0);
            ff  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len) : 0;
            sendFrame(len, bad, af, ff, $urandom_range(0, 2));
        end
        idleCycle();
        idleCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
